// File: rtl/unstriping_2to1_pkg.sv
// Shared lane-word definitions for the 2-lane receive path: default widths,
// lane word type and a helper that counts valid lanes.
package unstriping_2to1_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;
  localparam int LANE_W_DEF = DATA_W_DEF + 1;
  localparam int VALID_BIT  = DATA_W_DEF;

  typedef logic [LANE_W_DEF-1:0] lane_t;

  function automatic logic [1:0] lane_count(input logic v0, input logic v1);
    return {1'b0, v0} + {1'b0, v1};
  endfunction

endpackage

// File: rtl/unstriping_2to1_if.sv
// Handshake/bus bundle between the lane merger and its environment.
// The master drives lane words and out_ready; the slave is the merger itself.
interface unstriping_2to1_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int LANE_W = DATA_W + 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic [LANE_W-1:0] in0;
  logic [LANE_W-1:0] in1;
  logic              in_ready;
  logic [LANE_W-1:0] out0;
  logic              out_ready;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic              lane_err;

  modport master (
    output in0, in1, out_ready,
    input  in_ready, out0, fifo_count, overflow, lane_err
  );

  modport slave (
    input  in0, in1, out_ready,
    output in_ready, out0, fifo_count, overflow, lane_err
  );
endinterface

// File: rtl/unstriping_2to1_fifo.sv
// Dual-write / single-read storage: up to two entries written per cycle in
// order (d0 then d1), one popped per cycle, with a fill count one bit wider than the pointers.
module unstriping_2to1_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        i_wr_n,
  input  logic [DATA_W-1:0] i_wr_d0,
  input  logic [DATA_W-1:0] i_wr_d1,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [CNT_W-1:0]  o_count,
  output logic [CNT_W-1:0]  o_count_next
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_wr_ptr1;

  assign w_wr_ptr1    = r_wr_ptr + PTR_W'(1);
  assign o_rd_data    = r_mem[r_rd_ptr];
  assign o_count      = r_count;
  assign o_count_next = r_count + CNT_W'(i_wr_n) - CNT_W'(i_rd);

  // Storage array, wrapping pointers and fill count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_n != 2'd0) begin
        r_mem[r_wr_ptr] <= i_wr_d0;
      end
      if (i_wr_n == 2'd2) begin
        r_mem[w_wr_ptr1] <= i_wr_d1;
      end
      r_wr_ptr <= r_wr_ptr + PTR_W'(i_wr_n);
      if (i_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= o_count_next;
    end
  end
endmodule

// File: rtl/unstriping_2to1.sv
// Receive-side lane merger: folds two {valid,byte} lanes back into one ordered
// byte stream with ready/valid backpressure and sticky error flags.
module unstriping_2to1
  import unstriping_2to1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  unstriping_2to1_if.slave  bus
);
  localparam int LANE_W = DATA_W + 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              w_v0;
  logic              w_v1;
  logic [1:0]        w_wr_n;
  logic [DATA_W-1:0] w_wr_d0;
  logic [DATA_W-1:0] w_wr_d1;
  logic              w_load;
  logic              w_pop;
  logic [DATA_W-1:0] w_rd_data;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_next;

  logic              r_in_ready;
  logic [LANE_W-1:0] r_out0;
  logic              r_overflow;
  logic              r_lane_err;

  assign w_v0 = bus.in0[DATA_W];
  assign w_v1 = bus.in1[DATA_W];

  // Write steering: a lone lane1 byte goes into the first write slot.
  always_comb begin
    w_wr_n  = 2'd0;
    w_wr_d0 = bus.in0[DATA_W-1:0];
    w_wr_d1 = bus.in1[DATA_W-1:0];
    if (r_in_ready) begin
      w_wr_n = lane_count(w_v0, w_v1);
      if (w_v0) begin
        w_wr_d0 = bus.in0[DATA_W-1:0];
      end else begin
        w_wr_d0 = bus.in1[DATA_W-1:0];
      end
    end else begin
      w_wr_n = 2'd0;
    end
    w_load = !r_out0[DATA_W] || bus.out_ready;
    w_pop  = w_load && (w_count != '0);
  end

  unstriping_2to1_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_wr_n       (w_wr_n),
    .i_wr_d0      (w_wr_d0),
    .i_wr_d1      (w_wr_d1),
    .i_rd         (w_pop),
    .o_rd_data    (w_rd_data),
    .o_count      (w_count),
    .o_count_next (w_count_next)
  );

  // Acceptance, output register and sticky flags; in_ready leaves room for a full pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_ready <= 1'b0;
      r_out0     <= '0;
      r_overflow <= 1'b0;
      r_lane_err <= 1'b0;
    end else begin
      r_in_ready <= (w_count_next <= CNT_W'(DEPTH - 2));
      if (w_load) begin
        r_out0 <= w_pop ? {1'b1, w_rd_data} : '0;
      end
      if (!r_in_ready && (w_v0 || w_v1)) begin
        r_overflow <= 1'b1;
      end
      if (w_v1 && !w_v0) begin
        r_lane_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out0       = r_out0;
  assign bus.fifo_count = w_count;
  assign bus.overflow   = r_overflow;
  assign bus.lane_err   = r_lane_err;
endmodule

// File: tb/tb_unstriping_2to1.sv
// Bench for the 2:1 lane merger: a behavioural queue model checked every cycle,
// a byte scoreboard checked on each output handshake, plus a hand-derived vector table.
module tb_unstriping_2to1;
  import unstriping_2to1_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unstriping_2to1_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  unstriping_2to1 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_q [$];
  logic [7:0] exp_q [$];
  logic       m_ov, m_rdy, m_ovf, m_lerr;
  logic [7:0] m_od;

  typedef struct {
    logic v0; logic [7:0] d0; logic v1; logic [7:0] d1; logic ordy;
    logic e_ov; logic [7:0] e_od; logic [3:0] e_cnt; logic e_rdy; logic e_lerr;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_ov = 1'b0; m_od = 8'h00; m_rdy = 1'b0; m_ovf = 1'b0; m_lerr = 1'b0;
  endtask

  task automatic model_edge(input logic v0, input logic [7:0] d0, input logic v1,
                            input logic [7:0] d1, input logic ordy);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!m_ov || ordy) begin
        if (m_q.size() > 0) begin
          m_ov = 1'b1; m_od = m_q.pop_front();
        end else begin
          m_ov = 1'b0; m_od = 8'h00;
        end
      end
      if (m_rdy) begin
        if (v0) begin m_q.push_back(d0); exp_q.push_back(d0); end
        if (v1) begin m_q.push_back(d1); exp_q.push_back(d1); end
      end else if (v0 || v1) begin
        m_ovf = 1'b1;
      end
      if (v1 && !v0) m_lerr = 1'b1;
      m_rdy = (m_q.size() <= DEPTH - 2);
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(bus.out0[8]), 32'(m_ov));
    chk("out_data", 32'(bus.out0[7:0]), 32'(m_od));
    chk("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("lane_err", 32'(bus.lane_err), 32'(m_lerr));
  endtask

  // One clock cycle: drive, take the edge, update model, check.
  task automatic step(input logic v0, input logic [7:0] d0, input logic v1,
                      input logic [7:0] d1, input logic ordy);
    lane_t pre;
    bus.in0 = {v0, d0};
    bus.in1 = {v1, d1};
    bus.out_ready = ordy;
    pre = bus.out0;
    @(posedge clk);
    if (rst_n && pre[8] && ordy) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_underflow: actual=%0h required=none", pre[7:0]);
      end else begin
        chk("sb_order", 32'(pre[7:0]), 32'(exp_q.pop_front()));
      end
    end
    model_edge(v0, d0, v1, d1, ordy);
    #1;
    compare_all();
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() > 0 || m_ov) && cyc < 60) begin
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      cyc++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int sent;
    int cyc;
    logic [7:0] d;

    tbl[0]  = '{1'b1, 8'hA0, 1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 4'd2, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'hB2, 1'b1, 8'hB3, 1'b1, 1'b1, 8'hA0, 4'd3, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 4'd2, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB2, 4'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB3, 4'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 4'd0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'hC3, 1'b1, 1'b0, 8'h00, 4'd1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hC3, 4'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1};

    // Reset held with random inputs
    model_reset();
    for (int i = 0; i < 5; i++) begin
      bus.in0 = 9'($urandom); bus.in1 = 9'($urandom); bus.out_ready = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_out0", 32'(bus.out0), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_count", 32'(bus.fifo_count), 32'd0);
      chk("rst_flags", 32'({bus.overflow, bus.lane_err}), 32'd0);
    end
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("ready_after_release", 32'(bus.in_ready), 32'd1);

    // Ordering and single-lane table
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].ordy);
      chk("tbl_out_valid", 32'(bus.out0[8]), 32'(tbl[i].e_ov));
      chk("tbl_out_data", 32'(bus.out0[7:0]), 32'(tbl[i].e_od));
      chk("tbl_count", 32'(bus.fifo_count), 32'(tbl[i].e_cnt));
      chk("tbl_ready", 32'(bus.in_ready), 32'(tbl[i].e_rdy));
      chk("tbl_lane_err", 32'(bus.lane_err), 32'(tbl[i].e_lerr));
    end

    // Backpressure fill until in_ready drops
    for (int k = 0; k < 10 && m_rdy; k++) begin
      step(1'b1, 8'(8'h10 + 2 * k), 1'b1, 8'(8'h11 + 2 * k), 1'b0);
    end
    chk("full_count", 32'(bus.fifo_count), 32'(DEPTH - 1));
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("hold_out0", 32'(bus.out0), 32'h110);
    end

    // Overflow: byte presented while not ready is dropped
    step(1'b1, 8'hEE, 1'b0, 8'h00, 1'b0);
    chk("overflow_set", 32'(bus.overflow), 32'd1);
    drain();
    chk("overflow_sticky", 32'(bus.overflow), 32'd1);

    // Wrap stream with random backpressure
    sent = 0;
    cyc  = 0;
    while (sent < 3 * DEPTH && cyc < 400) begin
      d = 8'($urandom);
      if (m_rdy && (sent <= 3 * DEPTH - 2) && ($urandom_range(0, 1) == 1)) begin
        step(1'b1, d, 1'b1, d ^ 8'h5C, 1'($urandom_range(0, 1)));
        sent += 2;
      end else if (m_rdy) begin
        step(1'b1, d, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
        sent += 1;
      end else begin
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
      end
      cyc++;
    end
    chk("stream_sent", 32'(sent >= 3 * DEPTH), 32'd1);
    drain();

    // Reset asserted mid-burst
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'(8'h60 + k), 1'b1, 8'(8'h70 + k), 1'b0);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("async_out0", 32'(bus.out0), 32'd0);
    chk("async_count", 32'(bus.fifo_count), 32'd0);
    chk("async_ready", 32'(bus.in_ready), 32'd0);
    chk("async_flags", 32'({bus.overflow, bus.lane_err}), 32'd0);
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    end
    step(1'b1, 8'h3C, 1'b1, 8'h3D, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
